uart_rx_frame: RTL

Parametrised UART receiver. Successor to the fixed 8N1 receiver, adding:
- configurable data width and stop-bit count
- mid-bit sampling through a two-flop input synchroniser
- start-bit glitch rejection
- framing-error reporting, and optional parity checking

Sits between the board RX pin and the byte-stream consumers in the same clock domain.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_2ff.sv | 23 ++
 rtl/uart_rx_frame.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, legal frame ranges and baud divisor helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_PARITY    = 3'd3,
      ST_STOP      = 3'd4,
      ST_WAIT_HIGH = 3'd5
   } uart_state_e;

   localparam int unsigned DATA_BITS_MIN = 5;
   localparam int unsigned DATA_BITS_MAX = 9;
   localparam int unsigned STOP_BITS_MIN = 1;
   localparam int unsigned STOP_BITS_MAX = 2;

   // Clock cycles per bit period; integer division, so the rate error is the caller's concern.
   function automatic int unsigned uart_bit_cnt(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset to RESET_VAL.
module uart_sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver with mid-bit sampling, glitch rejection and framing checks.
// Define UART_RX_PARITY_EN to expect and check one parity bit between data and stop.
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ   = 100_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx_in_i,
   output logic [DATA_BITS-1:0] dout_o,
   output logic                 rx_done_tick_o,
   output logic                 frame_err_o,
   output logic                 parity_err_o,
   output logic                 busy_o
);

   localparam int unsigned BIT_CNT = uart_bit_cnt(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF    = BIT_CNT / 2;
   localparam int unsigned CW      = $clog2(BIT_CNT);
   localparam int unsigned NW      = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CNT_LAST  = CW'(BIT_CNT - 1);
   localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
   localparam logic [NW-1:0] DATA_LAST = NW'(DATA_BITS - 1);
   localparam logic [NW-1:0] STOP_LAST = NW'(STOP_BITS - 1);

   if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
       STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
       PARITY_ODD > 1 || BIT_CNT < 4) begin : g_param_check
      $error("uart_rx_frame: illegal parameter combination");
   end

   logic rxs;

   uart_sync_2ff #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_in_i),
      .q     (rxs)
   );

   uart_state_e          state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [NW-1:0]        nbit_q, nbit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 ferr_q, ferr_d;
   logic                 frame_err_q, frame_err_d;
   logic                 tick_q, tick_d;
   logic                 stop_fe;

`ifdef UART_RX_PARITY_EN
   localparam logic ODD = (PARITY_ODD != 0);
   logic perr_q, perr_d;
   logic parity_err_q, parity_err_d;
`endif

   assign stop_fe = ferr_q | ~rxs;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q + 1'b1;
      nbit_d      = nbit_q;
      shreg_d     = shreg_q;
      dout_d      = dout_q;
      ferr_d      = ferr_q;
      frame_err_d = frame_err_q;
      tick_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_d       = perr_q;
      parity_err_d = parity_err_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rxs) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d  = '0;
               nbit_d = '0;
               ferr_d = 1'b0;
`ifdef UART_RX_PARITY_EN
               perr_d = 1'b0;
`endif
               // A line that is high again at mid start bit was a glitch.
               state_d = rxs ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
               if (nbit_q == DATA_LAST) begin
                  nbit_d = '0;
`ifdef UART_RX_PARITY_EN
                  state_d = ST_PARITY;
`else
                  state_d = ST_STOP;
`endif
               end else begin
                  nbit_d = nbit_q + 1'b1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         ST_PARITY: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               perr_d  = rxs ^ (^shreg_q) ^ ODD;
               state_d = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d  = '0;
               ferr_d = stop_fe;
               if (nbit_q == STOP_LAST) begin
                  nbit_d      = '0;
                  tick_d      = 1'b1;
                  dout_d      = shreg_q;
                  frame_err_d = stop_fe;
`ifdef UART_RX_PARITY_EN
                  parity_err_d = perr_q;
`endif
                  // Leave at mid stop bit so a following start edge is not missed.
                  state_d = stop_fe ? ST_WAIT_HIGH : ST_IDLE;
               end else begin
                  nbit_d = nbit_q + 1'b1;
               end
            end
         end
         ST_WAIT_HIGH: begin
            cnt_d = '0;
            if (rxs) state_d = ST_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         nbit_q      <= '0;
         shreg_q     <= '0;
         dout_q      <= '0;
         ferr_q      <= 1'b0;
         frame_err_q <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         nbit_q      <= nbit_d;
         shreg_q     <= shreg_d;
         dout_q      <= dout_d;
         ferr_q      <= ferr_d;
         frame_err_q <= frame_err_d;
         tick_q      <= tick_d;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perr_q       <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         perr_q       <= perr_d;
         parity_err_q <= parity_err_d;
      end
   end

   assign parity_err_o = parity_err_q;
`else
   assign parity_err_o = 1'b0;
`endif

   assign dout_o         = dout_q;
   assign rx_done_tick_o = tick_q;
   assign frame_err_o    = frame_err_q;
   assign busy_o         = (state_q != ST_IDLE);

endmodule
